// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/ack bundle for mem_bus_arbiter (one instance per master).
// The err signal exists only when MEM_BUS_ERR_EN is defined.
interface mem_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
`ifdef MEM_BUS_ERR_EN
    logic          err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
`else
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
`endif
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared RAM/ROM bus.
// Optional MEM_BUS_ERR_EN adds per-master err pulses and out-of-range read zeroing.
module mem_bus_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int ROM_WORDS = 128,
`ifdef MEM_BUS_ERR_EN
    parameter int RAM_TOP   = 16'h0FFF + ROM_WORDS,
`endif
    parameter int READ_LAT  = 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    mem_bus_arbiter_if.slave m0,
    mem_bus_arbiter_if.slave m1,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_data,
    output logic             mem_wren,
    input  logic [DW-1:0]    ram_q,
    input  logic [DW-1:0]    rom_q,
    output logic             busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // One extra bit so a limit of 2**AW still compares correctly.
    localparam logic [AW:0] ROM_LIM  = (AW+1)'(ROM_WORDS);
    localparam logic [1:0]  LAT_LOAD = 2'(READ_LAT - 1);

    logic [1:0]    state;
    logic [1:0]    cnt;
    logic          sel;
    logic          we_l;
    logic          rom_l;
    logic          last_grant;
    logic          gnt;
    logic          gnt_we;
    logic          gnt_rom;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;
    logic [DW-1:0] rd_val;

`ifdef MEM_BUS_ERR_EN
    localparam logic [AW:0] TOP_LIM = (AW+1)'(RAM_TOP);
    logic oor_l;
    logic gnt_oor;
    logic done_err;
`endif

    // gnt: 0 selects M0, 1 selects M1; on a tie the master not served last wins.
    always_comb begin
        gnt       = (m0.req & m1.req) ? ~last_grant : m1.req;
        gnt_we    = gnt ? m1.we    : m0.we;
        gnt_addr  = gnt ? m1.addr  : m0.addr;
        gnt_wdata = gnt ? m1.wdata : m0.wdata;
        gnt_rom   = {1'b0, gnt_addr} < ROM_LIM;
`ifdef MEM_BUS_ERR_EN
        gnt_oor   = {1'b0, gnt_addr} >= TOP_LIM;
        done_err  = (we_l & rom_l) | oor_l;
        rd_val    = oor_l ? '0 : (rom_l ? rom_q : ram_q);
`else
        rd_val    = rom_l ? rom_q : ram_q;
`endif
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= 1'b0;
            we_l       <= 1'b0;
            rom_l      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            m0.ack     <= 1'b0;
            m1.ack     <= 1'b0;
            m0.rdata   <= '0;
            m1.rdata   <= '0;
`ifdef MEM_BUS_ERR_EN
            oor_l      <= 1'b0;
            m0.err     <= 1'b0;
            m1.err     <= 1'b0;
`endif
        end else begin
            m0.ack <= 1'b0;
            m1.ack <= 1'b0;
`ifdef MEM_BUS_ERR_EN
            m0.err <= 1'b0;
            m1.err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (m0.req | m1.req) begin
                        sel        <= gnt;
                        we_l       <= gnt_we;
                        rom_l      <= gnt_rom;
                        last_grant <= gnt;
                        mem_addr   <= gnt_addr;
                        mem_data   <= gnt_wdata;
                        mem_wren   <= gnt_we & ~gnt_rom;
`ifdef MEM_BUS_ERR_EN
                        oor_l      <= gnt_oor;
`endif
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_wren <= 1'b0;
                    if (we_l) begin
                        m0.ack <= ~sel;
                        m1.ack <= sel;
`ifdef MEM_BUS_ERR_EN
                        m0.err <= ~sel & done_err;
                        m1.err <= sel & done_err;
`endif
                        state  <= S_DONE;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (sel) m1.rdata <= rd_val;
                        else     m0.rdata <= rd_val;
                        m0.ack <= ~sel;
                        m1.ack <= sel;
`ifdef MEM_BUS_ERR_EN
                        m0.err <= ~sel & done_err;
                        m1.err <= sel & done_err;
`endif
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level timing model,
// plus directed literal checks and a READ_LAT=3 instance.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int ROM_WORDS = 128;
    localparam int LAT       = 1;
`ifdef MEM_BUS_ERR_EN
    localparam int RAM_TOP   = 16'h0FFF + ROM_WORDS;
`endif

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    int nvec = 0;
    int nerr = 0;

    // Master drive variables
    logic          r_req   [2];
    logic          r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    assign m0_if.req = r_req[0];   assign m0_if.we = r_we[0];
    assign m0_if.addr = r_addr[0]; assign m0_if.wdata = r_wdata[0];
    assign m1_if.req = r_req[1];   assign m1_if.we = r_we[1];
    assign m1_if.addr = r_addr[1]; assign m1_if.wdata = r_wdata[1];

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] rom_q;
    logic          busy;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .ROM_WORDS(ROM_WORDS), .READ_LAT(LAT)) dut (
        .Clock(Clock), .Resetn(Resetn), .m0(m0_if), .m1(m1_if),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .ram_q(ram_q), .rom_q(rom_q), .busy(busy)
    );

    // Second instance with three-cycle read latency, memory data driven directly
    logic          r3_req;
    logic          r3_we;
    logic [AW-1:0] r3_addr;
    logic [DW-1:0] r3_wdata;
    logic [AW-1:0] mem3_addr;
    logic [DW-1:0] mem3_data;
    logic          mem3_wren;
    logic [DW-1:0] ram3_q;
    logic [DW-1:0] rom3_q;
    logic          busy3;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) b0_if ();
    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) b1_if ();
    assign b0_if.req = r3_req;   assign b0_if.we = r3_we;
    assign b0_if.addr = r3_addr; assign b0_if.wdata = r3_wdata;
    assign b1_if.req = 1'b0;     assign b1_if.we = 1'b0;
    assign b1_if.addr = '0;      assign b1_if.wdata = '0;
    assign rom3_q = '0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .ROM_WORDS(ROM_WORDS), .READ_LAT(3)) dut3 (
        .Clock(Clock), .Resetn(Resetn), .m0(b0_if), .m1(b1_if),
        .mem_addr(mem3_addr), .mem_data(mem3_data), .mem_wren(mem3_wren),
        .ram_q(ram3_q), .rom_q(rom3_q), .busy(busy3)
    );

    // Environment memories: RAM with registered address and one-cycle q, ROM image
    logic [DW-1:0] env_ram [0:65535];
    logic [DW-1:0] rom_img [0:ROM_WORDS-1];
    always @(posedge Clock) begin
        if (mem_wren) env_ram[mem_addr] <= mem_data;
        ram_q <= env_ram[mem_addr];
        rom_q <= rom_img[mem_addr[6:0]];
    end

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a) ^ 16'hA5C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is granted when the bus is free, its ack lands
    // 1 (write) or 1+LAT (read) edges later, and the bus frees two edges after that.
    int            edge_n, grant_edge, ack_edge, free_edge;
    logic          last_m, cur_m, cur_we, cur_err;
    logic [DW-1:0] cur_rd;
    logic [DW-1:0] mram [0:65535];
    logic          e_ack [2];
    logic          e_err [2];
    logic [DW-1:0] e_rdata [2];
    logic          e_wren, e_busy;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mdata;
    logic          g_pick, g_we, g_rom, g_oor;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            edge_n = 0; grant_edge = -100; ack_edge = -100; free_edge = 0;
            last_m = 1'b1; cur_m = 1'b0; cur_we = 1'b0; cur_err = 1'b0; cur_rd = '0;
            e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
            e_rdata[0] = '0; e_rdata[1] = '0;
            e_wren = 1'b0; e_busy = 1'b0; e_maddr = '0; e_mdata = '0;
        end else begin
            edge_n++;
            e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
            e_wren = 1'b0;
            if (edge_n == ack_edge) begin
                e_ack[cur_m] = 1'b1;
                e_err[cur_m] = cur_err;
                if (!cur_we) e_rdata[cur_m] = cur_rd;
            end
            if (edge_n >= free_edge && (r_req[0] || r_req[1])) begin
                g_pick = (r_req[0] && (!r_req[1] || last_m)) ? 1'b0 : 1'b1;
                g_we   = r_we[g_pick];
                g_addr = r_addr[g_pick];
                g_data = r_wdata[g_pick];
                g_rom  = int'(g_addr) < ROM_WORDS;
`ifdef MEM_BUS_ERR_EN
                g_oor  = int'(g_addr) >= RAM_TOP;
                cur_err = (g_we && g_rom) || g_oor;
`else
                g_oor  = 1'b0;
                cur_err = 1'b0;
`endif
                cur_m = g_pick; cur_we = g_we; last_m = g_pick;
                grant_edge = edge_n;
                ack_edge   = edge_n + (g_we ? 1 : 1 + LAT);
                free_edge  = ack_edge + 2;
                cur_rd = g_oor ? '0 : (g_rom ? rom_img[g_addr[6:0]] : mram[g_addr]);
                if (g_we && !g_rom) mram[g_addr] = g_data;
                e_maddr = g_addr; e_mdata = g_data; e_wren = g_we && !g_rom;
            end
            e_busy = (edge_n >= grant_edge) && (edge_n <= ack_edge);
        end
    end

    always @(negedge Clock) begin
        chk("ack0", 32'(m0_if.ack), 32'(e_ack[0]));
        chk("ack1", 32'(m1_if.ack), 32'(e_ack[1]));
        chk("rdata0", 32'(m0_if.rdata), 32'(e_rdata[0]));
        chk("rdata1", 32'(m1_if.rdata), 32'(e_rdata[1]));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mem_wren", 32'(mem_wren), 32'(e_wren));
        chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
        chk("mem_data", 32'(mem_data), 32'(e_mdata));
`ifdef MEM_BUS_ERR_EN
        chk("err0", 32'(m0_if.err), 32'(e_err[0]));
        chk("err1", 32'(m1_if.err), 32'(e_err[1]));
`endif
    end

    task automatic cyc();
        @(negedge Clock);
        #1;
    endtask

    task automatic wait_ack(input int m, output int lat, output int wc);
        lat = 0; wc = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (mem_wren === 1'b1) wc++;
            if ((m == 1 ? m1_if.ack : m0_if.ack) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    logic [AW-1:0] bnd [4] = '{16'h007F, 16'h0080, 16'hFFFF, 16'h0000};

    task automatic new_fields(input int m);
        r_we[m] = 1'($urandom_range(1));
        case ($urandom_range(4))
            0:       r_addr[m] = AW'($urandom_range(ROM_WORDS - 1));
            1:       r_addr[m] = 16'h0200 + AW'($urandom_range(7));
            2:       r_addr[m] = AW'($urandom);
            default: r_addr[m] = bnd[$urandom_range(3)];
        endcase
        r_wdata[m] = DW'($urandom);
    endtask

    int lat, wc, n, lat3;
    int ord [4];
    logic [DW-1:0] dat [4];
    int exp_ord [4] = '{0, 1, 0, 1};

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_ram[i] = pat(i);
            mram[i]    = pat(i);
        end
        for (int i = 0; i < ROM_WORDS; i++) rom_img[i] = DW'(i * 257) ^ 16'h0F0F;
        rom_img[5] = 16'h1234;
        for (int m = 0; m < 2; m++) begin
            r_req[m] = 1'b0; r_we[m] = 1'b0; r_addr[m] = '0; r_wdata[m] = '0;
        end
        r3_req = 1'b0; r3_we = 1'b0; r3_addr = '0; r3_wdata = '0; ram3_q = '0;

        // Reset, then a read aborted by reset
        repeat (3) cyc();
        Resetn = 1'b1;
        cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack0", 32'(m0_if.ack), 0);
        chk("rst_rdata1", 32'(m1_if.rdata), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wren", 32'(mem_wren), 0);
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 16'h0200;
        cyc();
        Resetn = 1'b0; r_req[0] = 1'b0;
        repeat (3) cyc();
        Resetn = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (m0_if.ack === 1'b1 || m1_if.ack === 1'b1) n++;
        end
        chk("abort_ack_count", 32'(n), 0);
        chk("abort_busy", 32'(busy), 0);

        // Write then read back through RAM
        r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 16'h0200; r_wdata[0] = 16'hBEEF;
        wait_ack(0, lat, wc);
        chk("wr_lat", 32'(lat), 2);
        chk("wr_wren_cycles", 32'(wc), 1);
        r_req[0] = 1'b0;
        cyc();
        r_req[0] = 1'b1; r_we[0] = 1'b0;
        wait_ack(0, lat, wc);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_data", 32'(m0_if.rdata), 32'h0000BEEF);
        chk("model_rd_data", 32'(e_rdata[0]), 32'h0000BEEF);
        r_req[0] = 1'b0;
        cyc();

        // ROM read and ROM write
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0005;
        wait_ack(1, lat, wc);
        chk("rom_rd_lat", 32'(lat), 3);
        chk("rom_rd_data", 32'(m1_if.rdata), 32'h00001234);
        r_req[1] = 1'b0;
        cyc();
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_wdata[1] = 16'hDEAD;
        wait_ack(1, lat, wc);
        chk("rom_wr_lat", 32'(lat), 2);
        chk("rom_wr_wren", 32'(wc), 0);
`ifdef MEM_BUS_ERR_EN
        chk("rom_wr_err", 32'(m1_if.err), 1);
`endif
        r_req[1] = 1'b0;
        cyc();

        // Both masters requesting from reset, held across acks
        Resetn = 1'b0;
        cyc();
        Resetn = 1'b1;
        r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 16'h0300;
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0301;
        n = 0;
        for (int i = 0; i < 4; i++) begin ord[i] = 9; dat[i] = '0; end
        for (int k = 0; k < 40 && n < 4; k++) begin
            cyc();
            if (m0_if.ack === 1'b1) begin ord[n] = 0; dat[n] = m0_if.rdata; n++; end
            if (m1_if.ack === 1'b1 && n < 4) begin ord[n] = 1; dat[n] = m1_if.rdata; n++; end
        end
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        chk("rr_count", 32'(n), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
            chk($sformatf("rr_data%0d", i), 32'(dat[i]), (exp_ord[i] == 1) ? 32'h0000A6C2 : 32'h0000A6C3);
        end
        repeat (4) cyc();

        // Request dropped right after grant still completes exactly once
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0301;
        cyc();
        r_req[1] = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (m1_if.ack === 1'b1) n++;
        end
        chk("drop_ack_count", 32'(n), 1);
        chk("drop_rdata", 32'(m1_if.rdata), 32'h0000A6C2);
        chk("drop_busy", 32'(busy), 0);

        // READ_LAT=3 instance: ack 4 edges after grant, q sampled at the last WAIT edge
        r3_addr = 16'h0400; r3_we = 1'b0; r3_wdata = 16'h5555; r3_req = 1'b1; ram3_q = 16'h1000;
        lat3 = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (b0_if.ack === 1'b1) begin lat3 = k; break; end
            ram3_q = 16'h1000 + DW'(k);
        end
        r3_req = 1'b0;
        chk("lat3_ack_cycle", 32'(lat3), 5);
        chk("lat3_rdata", 32'(b0_if.rdata), 32'h00001004);
        chk("lat3_mem_addr", 32'(mem3_addr), 32'h00000400);
        chk("lat3_mem_data", 32'(mem3_data), 32'h00005555);
        chk("lat3_wren", 32'(mem3_wren), 0);
        repeat (2) cyc();
        chk("lat3_busy", 32'(busy3), 0);
        chk("lat3_ack1", 32'(b1_if.ack), 0);
        chk("lat3_rdata1", 32'(b1_if.rdata), 0);

        // Randomized traffic; fields may change or req may drop once granted
        for (int c = 0; c < 4000; c++) begin
            for (int m = 0; m < 2; m++) begin
                logic fl;
                fl = e_busy && (int'(cur_m) == m) && !e_ack[m];
                if (r_req[m]) begin
                    if (e_ack[m]) begin
                        if ($urandom_range(1) == 1) new_fields(m);
                        else r_req[m] = 1'b0;
                    end else if (fl) begin
                        if ($urandom_range(7) == 0) r_req[m] = 1'b0;
                        if ($urandom_range(3) == 0) new_fields(m);
                    end
                end else if (!fl && !e_ack[m] && $urandom_range(3) == 0) begin
                    r_req[m] = 1'b1;
                    new_fields(m);
                end
            end
            cyc();
        end
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        repeat (10) cyc();
        chk("final_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        nerr++;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter and sequencer for the shared memory bus in the pratica_2 system.
- Masters: processor (M0) and loader/debug port (M1).
- Decodes each request to the ROM region (low addresses) or the RAM region.
- Drives the single-port synchronous RAM/ROM control lines, absorbs their registered-address read latency, and returns data with a one-cycle ack pulse.
- Sits between `processador` and the `ram_lpm`/`rom_lpm` instances.

Parameters:
- AW, 16: address width.
- DW, 16: data width.
- ROM_WORDS, 128: addresses 0..ROM_WORDS-1 map to ROM; all others map to RAM.
- READ_LAT, 1: cycles from memory address sample to valid q (1..3).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous reset, active-low.
- m0_req  in  1  M0 request; held until m0_ack.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  AW  M0 address.
- m0_wdata  in  DW  M0 write data.
- m0_ack  out  1  M0 completion pulse, 1 cycle.
- m0_rdata  out  DW  M0 read data; valid with ack, held until next M0 ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as M0, for M1.
- mem_addr  out  AW  registered address to RAM and ROM.
- mem_data  out  DW  registered write data to RAM.
- mem_wren  out  1  RAM write enable, registered.
- ram_q  in  DW  RAM read data.
- rom_q  in  DW  ROM read data.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset (async, Resetn=0): state=IDLE; mem_addr=0, mem_data=0, mem_wren=0; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; last_grant=M1, so M0 wins the first tie; busy=0. Reset mid-transaction aborts it; no ack is ever produced for it.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, arbitration:
  - Only one req high: grant it.
  - Both high: round-robin; grant the master not in last_grant.
  - At grant edge: latch sel, we, region (rom = addr < ROM_WORDS).
  - Same edge: mem_addr<=addr, mem_data<=wdata, mem_wren<=we & ~rom.
  - Next state ACCESS; last_grant<=sel.
- ACCESS (1 cycle):
  - mem_wren<=0 at exit; a write lasts exactly one cycle.
  - Write: next DONE, ack asserted.
  - Read: next WAIT; counter loaded with READ_LAT-1.
- WAIT:
  - Decrement each cycle.
  - At 0: rdata(sel) <= rom ? rom_q : ram_q; ack(sel)<=1; next DONE.
- DONE: ack high this cycle only; next IDLE. mem_addr holds its last value.
- Latency, req sampled at edge E0:
  - Write: ack high in the cycle after E1.
  - Read: ack high in the cycle after E(1+READ_LAT); READ_LAT=1 gives ack after E2.
  - Minimum request-to-request spacing: 3 cycles (write) or 3+READ_LAT (read).
- Request rules:
  - Master signals are sampled only at grant. Later changes, including dropping req, do not cancel an accepted transaction; ack is still pulsed.
  - req still high in the IDLE cycle after ack counts as a new request. Round-robin then serves the other master first if it is requesting.
- Writes to the ROM region: mem_wren stays 0, memory contents unchanged, ack still pulsed.
- Address compare is unsigned over the full AW bits.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- Defined:
  - Adds outputs m0_err and m1_err (1 bit each).
  - err pulses with ack when the transaction was a ROM-region write, or an address at or above RAM_TOP (extra parameter, default 16'h0FFF + ROM_WORDS).
  - Out-of-range reads return 0.
- Undefined: no err ports; ROM writes are silently dropped; out-of-range reads return ram_q.

Test Plan:
1. Reset then idle: Resetn=0 for 3 cycles mid-read -> all outputs 0, no ack after release, busy=0.
2. M0 write addr=16'h0200, data=16'hBEEF, then M0 read 16'h0200 -> mem_wren high exactly 1 cycle; write ack one cycle after E1; read ack after E2 with m0_rdata=16'hBEEF.
3. ROM read: M1 reads addr 16'h0005 with rom_q=16'h1234 -> m1_rdata=16'h1234. M1 write to 16'h0005 -> mem_wren never high, ack pulses (err pulses if MEM_BUS_ERR_EN).
4. Simultaneous requests: both req high from reset, each reading a distinct RAM address, both held after ack -> grant order M0, M1, M0, M1; every ack on the correct master with the correct data.
5. Request dropped after grant: M1 read granted, m1_req deasserted in ACCESS -> m1_ack still pulses once; no second transaction.
6. READ_LAT=3 build: M0 read of RAM -> ack exactly 4 edges after grant; ram_q sampled at the final WAIT edge only.
